// File: rtl/spi_cmd_decoder_pkg.sv
// Shared constants for the SPI command decoder: FSM encodings, command
// byte layout and the default status byte.
package spi_cmd_decoder_pkg;

  localparam logic [2:0] ST_CMD     = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_CAP  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;

  localparam int         CMD_RW_BIT     = 7;
  localparam logic [7:0] STATUS_DEFAULT = 8'hA5;

  // A command byte with the rw bit set opens a write burst.
  function automatic logic is_write_cmd(input logic [7:0] b);
    return b[CMD_RW_BIT];
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_sync_2ff.sv
// Generic two-flop bit synchronizer with a parameterised reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability time before the value is used.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns the spi_target RX byte stream into register-bus reads/writes and
// supplies the next byte for spi_target to shift out.
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int         ADDR_W   = 7,
  parameter bit         AUTO_INC = 1'b1,
  parameter logic [7:0] STATUS   = STATUS_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ss_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(AUTO_INC);

  logic              ss_sync;
  logic              ss_prev_q;
  logic              desel;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_q,    tx_d;
  logic              we_q,    we_d;
  logic              re_q,    re_d;
  logic              busy_q,  busy_d;

  sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ss_n),
    .o_q   (ss_sync)
  );

  // Deselect = rising edge of the synchronized chip select.
  assign desel = ss_sync & ~ss_prev_q;

  // Next-state, address and data path; deselect is applied last so that a
  // coincident byte is still processed before the frame closes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    we_d    = 1'b0;
    // Post-write increment lands the cycle after the strobe.
    if (we_q) addr_d = addr_q + ADDR_INC;
    case (state_q)
      ST_CMD: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_data[ADDR_W-1:0];
          state_d = is_write_cmd(i_rx_data) ? ST_WR : ST_RD_REQ;
        end
      end
      ST_WR: begin
        if (i_rx_valid) begin
          wdata_d = i_rx_data;
          we_d    = 1'b1;
        end
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        tx_d    = i_reg_rdata;
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        // MOSI byte is a dummy; prefetch the next location.
        if (i_rx_valid) begin
          addr_d  = addr_q + ADDR_INC;
          state_d = ST_RD_REQ;
        end
      end
      default: state_d = ST_CMD;
    endcase
    if (desel) begin
      state_d = ST_CMD;
      tx_d    = STATUS;
    end
    // Read strobe is registered so it is high exactly during RD_REQ.
    re_d   = (state_d == ST_RD_REQ);
    busy_d = (state_d != ST_CMD);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_CMD;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_q      <= STATUS;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      ss_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      we_q      <= we_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      ss_prev_q <= ss_sync;
    end
  end

  assign o_tx_data   = tx_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_we    = we_q;
  assign o_reg_re    = re_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed frames plus random
// read/write bursts, checked against a frame-level model.
module tb_spi_cmd_decoder;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_ss_n = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_reg_rdata;
  logic [7:0] o_tx_data;
  logic [6:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_we, o_reg_re, o_busy;

  spi_cmd_decoder #(.ADDR_W(7), .AUTO_INC(1'b1), .STATUS(8'hA5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ss_n(i_ss_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
    .o_reg_we(o_reg_we), .o_reg_re(o_reg_re), .i_reg_rdata(i_reg_rdata),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } bus_ev_t;

  bus_ev_t    exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] fb[$];
  logic [7:0] ref_mem[128];
  logic [7:0] slv_mem[128];
  logic       load_mem = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Model state: frame-level view of the command protocol.
  logic       m_have_cmd = 1'b0;
  logic       m_wr = 1'b0;
  logic [6:0] m_addr = 7'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register slave: 1-cycle read latency, writes land on the strobe edge.
  always @(posedge i_clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) slv_mem[i] <= ref_mem[i];
    end else begin
      if (o_reg_we) slv_mem[o_reg_addr] <= o_reg_wdata;
      if (o_reg_re) i_reg_rdata <= slv_mem[o_reg_addr];
    end
  end

  // Monitor: compares every strobe and every byte launch to the queues.
  always @(negedge i_clk) begin
    if (i_rx_valid) begin
      if (exp_tx.size() == 0) check("tx_unexpected_byte", 32'(o_tx_data), 32'h1FF);
      else check("tx_data", 32'(o_tx_data), 32'(exp_tx.pop_front()));
    end
    if (o_reg_we && o_reg_re) check("we_re_overlap", 32'd1, 32'd0);
    if (o_reg_we || o_reg_re) begin
      if (exp_bus.size() == 0) begin
        check("unexpected_strobe", {15'd0, o_reg_we, o_reg_addr, o_reg_wdata}, 32'h0);
      end else begin
        bus_ev_t e;
        e = exp_bus.pop_front();
        check("strobe_kind_we", 32'(o_reg_we), 32'(e.wr));
        check("strobe_addr", 32'(o_reg_addr), 32'(e.addr));
        if (e.wr) check("we_data", 32'(o_reg_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Reference model: one call per byte presented by the master.
  task automatic model_byte(input logic [7:0] b);
    if (!m_have_cmd) begin
      exp_tx.push_back(8'hA5);
      m_have_cmd = 1'b1;
      m_wr       = b[7];
      m_addr     = b[6:0];
      if (!m_wr) exp_bus.push_back('{wr: 1'b0, addr: m_addr, data: 8'h00});
    end else if (m_wr) begin
      exp_tx.push_back(8'hA5);
      exp_bus.push_back('{wr: 1'b1, addr: m_addr, data: b});
      ref_mem[m_addr] = b;
      m_addr = m_addr + 7'd1;
    end else begin
      exp_tx.push_back(ref_mem[m_addr]);
      m_addr = m_addr + 7'd1;
      exp_bus.push_back('{wr: 1'b0, addr: m_addr, data: 8'h00});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
    tick(7);
  endtask

  task automatic close_frame();
    i_ss_n     = 1'b1;
    m_have_cmd = 1'b0;
    tick(6);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_tx", 32'(o_tx_data), 32'hA5);
  endtask

  task automatic run_frame();
    i_ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i]);
      if (i == 0) check("busy_in_frame", 32'(o_busy), 32'd1);
    end
    close_frame();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h12] = 8'h77;
    ref_mem[8'h13] = 8'h88;
    load_mem = 1'b1;
    tick(3);
    load_mem = 1'b0;
    check("rst_tx", 32'(o_tx_data), 32'hA5);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_addr", 32'(o_reg_addr), 32'd0);
    check("rst_wdata", 32'(o_reg_wdata), 32'd0);
    i_rst = 1'b0;

    // Idle: status byte, not busy, no strobes (monitor flags any strobe).
    for (int i = 0; i < 10; i++) begin
      tick(10);
      check("idle_tx_status", 32'(o_tx_data), 32'hA5);
      check("idle_not_busy", 32'(o_busy), 32'd0);
    end

    // Single write to 0x05.
    fb = {8'h85, 8'h3C};
    run_frame();
    // Read burst from 0x12.
    fb = {8'h12, 8'h00, 8'h00};
    run_frame();
    // Write burst wrapping 0x7F -> 0x00.
    fb = {8'hFF, 8'h01, 8'h02};
    run_frame();

    // Reset between write command and data: the data byte becomes a command.
    i_ss_n = 1'b0;
    tick(4);
    send_byte(8'h81);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    m_have_cmd = 1'b0;
    check("midrst_addr", 32'(o_reg_addr), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    tick(2);
    send_byte(8'h9A);
    send_byte(8'h55);
    close_frame();

    // Write data byte coincident with the internal deselect edge.
    i_ss_n = 1'b0;
    tick(4);
    send_byte(8'hC0);
    model_byte(8'h66);
    i_ss_n = 1'b1;
    tick(2);
    i_rx_data  = 8'h66;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
    m_have_cmd = 1'b0;
    tick(6);
    check("desel_busy", 32'(o_busy), 32'd0);
    fb = {8'h83, 8'h11};
    run_frame();

    // Random read/write bursts.
    for (int f = 0; f < 25; f++) begin
      logic [7:0] cmd;
      int         n;
      cmd = 8'($urandom);
      n   = $urandom_range(1, 4);
      fb  = {cmd};
      for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
      run_frame();
    end

    tick(10);
    check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
